// File: rtl/enemy_sched_pkg.sv
// Shared types and constants for the enemy wave scheduler: game states,
// spawn LFSR seed/taps and the on-screen clamp window for spawn_x.
package enemy_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  // Fibonacci LFSR x^10 + x^7 + 1: taps 10 and 7 are bit indices 9 and 6.
  localparam logic [9:0] LFSR_SEED   = 10'h155;
  localparam int         LFSR_TAP_HI = 9;
  localparam int         LFSR_TAP_LO = 6;

  localparam logic [9:0] SPAWN_X_MIN = 10'd5;
  localparam logic [9:0] SPAWN_X_MAX = 10'd605;

  localparam logic [3:0] WAVE_MAX  = 4'd9;
  localparam logic [7:0] SCORE_MAX = 8'd255;

  function automatic logic [9:0] clamp_x(input logic [9:0] v);
    if (v < SPAWN_X_MIN)      return SPAWN_X_MIN;
    else if (v > SPAWN_X_MAX) return SPAWN_X_MAX;
    else                      return v;
  endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// Free-running 10-bit Fibonacci LFSR used as the spawn x-position source.
module spawn_lfsr
  import enemy_sched_pkg::*;
(
  input  logic       Clk,
  input  logic       RESET,
  output logic [9:0] lfsr
);

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[8:0], lfsr[LFSR_TAP_HI] ^ lfsr[LFSR_TAP_LO]};
    end
  end

endmodule

// File: rtl/enemy_wave_scheduler.sv
// Game flow controller: sequences enemy slots, counts kills into score and
// waves, applies respawn delays and the inter-wave pause.
module enemy_wave_scheduler
  import enemy_sched_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int RESPAWN_FRAMES = 120,
  parameter int KILLS_PER_WAVE = 8,
  parameter int PAUSE_FRAMES   = 180
) (
  input  logic                 Clk,
  input  logic                 RESET,
  input  logic                 frame_clk,
  input  logic                 start,
  input  logic                 dead,
  input  logic [NUM_SLOTS-1:0] kill,
  output logic [NUM_SLOTS-1:0] enemy_en,
  output logic [NUM_SLOTS-1:0] enemy_spawn,
  output logic [9:0]           spawn_x,
  output logic [3:0]           wave,
  output logic [7:0]           score,
  output logic [1:0]           game_state
);

  localparam int TW  = (RESPAWN_FRAMES > 0) ? $clog2(RESPAWN_FRAMES + 1) : 1;
  localparam int PW  = (PAUSE_FRAMES > 0) ? $clog2(PAUSE_FRAMES + 1) : 1;
  localparam int PCW = $clog2(NUM_SLOTS + 1);
  localparam int KCW = $clog2(KILLS_PER_WAVE + 2 * NUM_SLOTS + 1);

  localparam logic [TW-1:0]  RESPAWN_LOAD = TW'(RESPAWN_FRAMES);
  localparam logic [PW-1:0]  PAUSE_LOAD   = PW'(PAUSE_FRAMES);
  localparam logic [KCW-1:0] KILL_TARGET  = KCW'(KILLS_PER_WAVE);

  game_state_e          state;
  logic                 frame_d;
  logic                 frame_tick;
  logic [TW-1:0]        timer [NUM_SLOTS];
  logic [PW-1:0]        pause_cnt;
  logic [KCW-1:0]       kill_cnt;
  logic [9:0]           lfsr;

  logic [NUM_SLOTS-1:0] accepted;
  logic [NUM_SLOTS-1:0] spawn_vec;
  logic [PCW-1:0]       kill_pop;
  logic [8:0]           score_sum;
  logic [7:0]           score_next;
  logic [KCW-1:0]       kc_sum;
  logic                 found;

  assign game_state = state;

  spawn_lfsr u_lfsr (
    .Clk   (Clk),
    .RESET (RESET),
    .lfsr  (lfsr)
  );

  // frame_clk is only sampled here; the registered edge detect gives a
  // clean single-Clk tick two Clk after the frame_clk rising edge.
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      frame_d    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_d    <= frame_clk;
      frame_tick <= frame_clk & ~frame_d;
    end
  end

  always_comb begin
    accepted = kill & enemy_en;
    kill_pop = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      kill_pop = kill_pop + PCW'(accepted[i]);
    end
    score_sum  = {1'b0, score} + 9'(kill_pop);
    score_next = score_sum[8] ? SCORE_MAX : score_sum[7:0];
    kc_sum     = kill_cnt + KCW'(kill_pop);

    // Lowest eligible slot among the first wave+1; a slot being killed this
    // Clk is never eligible, so a same-cycle kill always wins.
    spawn_vec = '0;
    found     = 1'b0;
    if (state == ST_RUN && frame_tick) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (!found && (i <= int'(wave)) && !enemy_en[i] &&
            (timer[i] == '0) && !accepted[i]) begin
          spawn_vec[i] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  end

  // enemy_spawn[i] is a one-Clk strobe; spawn_x is valid only while some
  // strobe bit is high and simply holds its last value otherwise.
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state       <= ST_IDLE;
      enemy_en    <= '0;
      enemy_spawn <= '0;
      spawn_x     <= '0;
      wave        <= '0;
      score       <= '0;
      kill_cnt    <= '0;
      pause_cnt   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) timer[i] <= '0;
    end else begin
      enemy_spawn <= '0;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state     <= ST_RUN;
            enemy_en  <= '0;
            wave      <= '0;
            score     <= '0;
            kill_cnt  <= '0;
            pause_cnt <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) timer[i] <= '0;
          end
        end
        ST_RUN, ST_PAUSE: begin
          if (dead) begin
            state     <= ST_OVER;
            enemy_en  <= '0;
            pause_cnt <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) timer[i] <= '0;
          end else begin
            score       <= score_next;
            enemy_en    <= (enemy_en & ~accepted) | spawn_vec;
            enemy_spawn <= spawn_vec;
            if (|spawn_vec) spawn_x <= clamp_x(lfsr);
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (accepted[i])                       timer[i] <= RESPAWN_LOAD;
              else if (frame_tick && timer[i] != '0) timer[i] <= timer[i] - TW'(1);
            end
            // Kills taken during a pause carry over and can trigger the next
            // advance on the first RUN cycle.
            if (state == ST_RUN && kc_sum >= KILL_TARGET) begin
              kill_cnt  <= kc_sum - KILL_TARGET;
              wave      <= (wave == WAVE_MAX) ? wave : wave + 4'd1;
              state     <= ST_PAUSE;
              pause_cnt <= PAUSE_LOAD;
            end else begin
              kill_cnt <= kc_sum;
              if (state == ST_PAUSE && frame_tick) begin
                if (pause_cnt <= PW'(1)) begin
                  pause_cnt <= '0;
                  state     <= ST_RUN;
                end else begin
                  pause_cnt <= pause_cnt - PW'(1);
                end
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_wave_scheduler.sv
// Directed bench for enemy_wave_scheduler with default parameters.
module tb_enemy_wave_scheduler;

  logic       Clk;
  logic       RESET;
  logic       frame_clk;
  logic       start;
  logic       dead;
  logic [3:0] kill;
  logic [3:0] enemy_en;
  logic [3:0] enemy_spawn;
  logic [9:0] spawn_x;
  logic [3:0] wave;
  logic [7:0] score;
  logic [1:0] game_state;

  int         errors;
  int         checks;
  int         spawn_cnt;
  logic [3:0] spawn_acc;
  int         exp_score;
  logic [3:0] mask;
  logic [3:0] exp_q[$];

  enemy_wave_scheduler dut (
    .Clk         (Clk),
    .RESET       (RESET),
    .frame_clk   (frame_clk),
    .start       (start),
    .dead        (dead),
    .kill        (kill),
    .enemy_en    (enemy_en),
    .enemy_spawn (enemy_spawn),
    .spawn_x     (spawn_x),
    .wave        (wave),
    .score       (score),
    .game_state  (game_state)
  );

  // clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One frame_clk period; on return the tick's effects are visible.
  task automatic frame();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
    spawn_acc = spawn_acc | enemy_spawn;
    if (enemy_spawn != 4'b0000) spawn_cnt++;
  endtask

  task automatic kill_slots(input logic [3:0] m);
    kill = m;
    step();
    kill = 4'b0000;
  endtask

  function automatic logic [3:0] limit_mask(input logic [3:0] m, input int rem);
    logic [3:0] o;
    int n;
    o = 4'b0000;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (m[i] && n < rem) begin
        o[i] = 1'b1;
        n++;
      end
    end
    return o;
  endfunction

  initial begin
    errors    = 0;
    checks    = 0;
    spawn_cnt = 0;
    spawn_acc = 4'b0000;
    RESET     = 1'b1;
    frame_clk = 1'b0;
    start     = 1'b0;
    dead      = 1'b0;
    kill      = 4'b0000;
    #2 RESET = 1'b0;
    repeat (3) step();

    check("rst_state", game_state, 0);
    check("rst_en", enemy_en, 0);
    check("rst_spawn", enemy_spawn, 0);
    check("rst_spawn_x", spawn_x, 0);
    check("rst_wave", wave, 0);
    check("rst_score", score, 0);

    RESET = 1'b1;
    step();
    check("post_rst_state", game_state, 0);
    check("post_rst_spawn", enemy_spawn, 0);

    // start a game
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_state", game_state, 1);
    check("start_score", score, 0);
    check("start_en", enemy_en, 0);

    // wave 0: only slot 0 ever spawns
    frame();
    check("first_spawn", enemy_spawn, 4'b0001);
    check("spawn_x_in_range", (spawn_x >= 10'd5 && spawn_x <= 10'd605), 1);
    frame();
    frame();
    check("spawn_once", spawn_cnt, 1);
    check("wave0_en", enemy_en, 4'b0001);

    // kill slot 0, then a kill on a disabled slot is ignored
    kill_slots(4'b0001);
    check("kill_score", score, 1);
    check("kill_en", enemy_en, 0);
    kill_slots(4'b0010);
    check("ignored_kill_score", score, 1);
    spawn_acc = 4'b0000;
    repeat (120) frame();
    check("no_early_respawn", spawn_acc, 0);
    frame();
    check("respawn_121", enemy_spawn, 4'b0001);

    // kills 2..8 advance to wave 1
    for (int k = 2; k <= 8; k++) begin
      kill_slots(4'b0001);
      check("score_k", score, k);
      if (k < 8) begin
        repeat (121) frame();
        check("respawn_k", enemy_en, 4'b0001);
      end
    end
    check("wave1", wave, 1);
    check("pause_state", game_state, 2);

    spawn_acc = 4'b0000;
    repeat (179) frame();
    check("still_pause", game_state, 2);
    check("pause_no_spawn", spawn_acc, 0);
    frame();
    check("pause_end", game_state, 1);
    check("pause_end_no_spawn", enemy_spawn, 0);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    while (exp_q.size() > 0) begin
      frame();
      check("post_pause_spawn", enemy_spawn, exp_q.pop_front());
    end
    check("wave1_en", enemy_en, 4'b0011);

    // run the score up to 254
    exp_score = 8;
    for (int it = 0; it < 20000 && exp_score < 254; it++) begin
      frame();
      mask = limit_mask(enemy_en, 254 - exp_score);
      if (mask != 4'b0000) begin
        kill_slots(mask);
        exp_score += $countones(mask);
      end
    end
    for (int it = 0; it < 1000 && enemy_en[1:0] != 2'b11; it++) frame();
    check("pre_sat_en", enemy_en[1:0], 2'b11);
    check("pre_sat_score", score, exp_score);
    check("wave_saturated", wave, 9);
    kill_slots(4'b0011);
    check("score_saturated", score, 255);
    check("sat_kill_en", enemy_en[1:0], 2'b00);

    // death with three live enemies
    for (int it = 0; it < 1000 && enemy_en != 4'b1111; it++) frame();
    check("four_live", enemy_en, 4'b1111);
    kill_slots(4'b0001);
    check("score_held_255", score, 255);
    check("three_live", enemy_en, 4'b1110);
    dead = 1'b1;
    kill = 4'b0010;
    step();
    dead = 1'b0;
    kill = 4'b0000;
    check("over_state", game_state, 3);
    check("over_en", enemy_en, 0);
    check("over_score", score, 255);
    check("over_wave", wave, 9);
    frame();
    check("over_no_spawn", enemy_spawn, 0);
    check("over_still", game_state, 3);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_state", game_state, 1);
    check("restart_score", score, 0);
    check("restart_wave", wave, 0);

    // async reset mid-RUN, right after a spawn pulse
    frame();
    check("restart_spawn", enemy_spawn, 4'b0001);
    kill_slots(4'b0001);
    check("restart_kill_score", score, 1);
    repeat (121) frame();
    check("pre_async_spawn", enemy_spawn, 4'b0001);
    #2 RESET = 1'b0;
    #1;
    check("async_state", game_state, 0);
    check("async_en", enemy_en, 0);
    check("async_spawn", enemy_spawn, 0);
    check("async_spawn_x", spawn_x, 0);
    check("async_score", score, 0);
    check("async_wave", wave, 0);
    #3 RESET = 1'b1;
    step();
    check("release_state", game_state, 0);
    check("release_spawn", enemy_spawn, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/enemy_wave_scheduler.md
ENEMY_WAVE_SCHEDULER -- requirements
Module: enemy_wave_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of enemy slots sequenced.
REQ-002 SHALL have parameter RESPAWN_FRAMES, default 120, frames a killed slot stays empty.
REQ-003 SHALL have parameter KILLS_PER_WAVE, default 8, kills needed to advance one wave.
REQ-004 SHALL have parameter PAUSE_FRAMES, default 180, frames of no spawning after a wave advance.
REQ-005 SHALL have port Clk, input, 1, the only clock (50 MHz).
REQ-006 SHALL have port RESET, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port frame_clk, input, 1, vsync-rate frame clock, sampled in Clk domain.
REQ-008 SHALL have port start, input, 1, level; begins a game from IDLE or OVER.
REQ-009 SHALL have port dead, input, 1, level; player died.
REQ-010 SHALL have port kill, input, NUM_SLOTS, per-slot collision pulse from the enemy FSMs.
REQ-011 SHALL have port enemy_en, output, NUM_SLOTS, slot active (drives the enemy hat_on gating).
REQ-012 SHALL have port enemy_spawn, output, NUM_SLOTS, one-Clk pulse loading a slot's start position.
REQ-013 SHALL have port spawn_x, output, 10, x start position, valid while any enemy_spawn bit is high.
REQ-014 SHALL have port wave, output, 4, current wave 0..9.
REQ-015 SHALL have port score, output, 8, kill count, saturating.
REQ-016 SHALL have port game_state, output, 2, IDLE=0, RUN=1, PAUSE=2, OVER=3.

Function
REQ-017 SHALL derive frame_tick as a one-Clk pulse, registered, on frame_clk rising edge (frame_clk delayed one Clk); 2-Clk latency from frame_clk edge.
REQ-018 SHALL implement states IDLE, RUN, PAUSE, OVER; IDLE/OVER + start -> RUN with score=0, wave=0, kill count=0, all timers=0, enemy_en=0.
REQ-019 SHALL, in RUN/PAUSE with dead=1, go to OVER next Clk, clear enemy_en and timers, hold score and wave; dead beats every other event that cycle.
REQ-020 SHALL compute allowed slots = min(wave+1, NUM_SLOTS).
REQ-021 SHALL, in RUN on frame_tick only, spawn at most one slot: lowest index i < allowed with enemy_en[i]=0 and timer[i]=0; set enemy_en[i]=1, pulse enemy_spawn[i] for exactly that Clk.
REQ-022 SHALL ignore kill[i] when enemy_en[i]=0.
REQ-023 SHALL, on kill[i] with enemy_en[i]=1 (any Clk, RUN or PAUSE), clear enemy_en[i] next Clk and load timer[i]=RESPAWN_FRAMES.
REQ-024 SHALL add popcount of accepted kills to score in the same Clk, saturating at 255, and to the kill count.
REQ-025 SHALL decrement each nonzero timer by 1 per frame_tick; a slot is spawn-eligible in the frame_tick after it reaches 0.
REQ-026 SHALL, when kill count reaches or crosses KILLS_PER_WAVE in RUN, subtract KILLS_PER_WAVE, increment wave saturating at 9, enter PAUSE with pause counter=PAUSE_FRAMES.
REQ-027 SHALL, in PAUSE, keep live enemies enabled, spawn nothing, decrement pause counter per frame_tick, return to RUN when it reaches 0.
REQ-028 SHALL generate spawn_x from a 10-bit Fibonacci LFSR (taps 10,7; seed 10'h155; never zero) advancing every Clk; spawn_x = LFSR clamped to [5, 605].
REQ-029 SHALL, when a kill and spawn hit the same slot in the same Clk, apply the kill and suppress the spawn.

Reset
REQ-030 SHALL, on RESET=0, asynchronously set game_state=IDLE, enemy_en=0, enemy_spawn=0, spawn_x=0, wave=0, score=0, all counters 0, LFSR=10'h155, frame_clk delay register=0.
REQ-031 SHALL resume from IDLE on RESET release regardless of state at assertion; no spawn pulse in the first Clk after release.

Structure
REQ-032 SHALL place the state enum, state encodings, LFSR seed/taps and spawn_x clamp bounds in package enemy_sched_pkg.
REQ-033 SHALL instantiate one sub-module spawn_lfsr (10-bit LFSR with async active-low reset); all else inline.

Verification
REQ-034 SHALL check: reset, start=1, 3 frame_ticks -> only slot 0 spawns (wave 0), enemy_spawn=4'b0001 once, spawn_x in [5,605].
REQ-035 SHALL check: kill[0] at enemy_en[0]=1 -> score 0->1, enemy_en[0]=0; no respawn until 121st frame_tick after kill.
REQ-036 SHALL check: 8 accepted kills -> wave=1, game_state=PAUSE for 180 frame_ticks, then slots 0 and 1 respawn on successive ticks.
REQ-037 SHALL check: kill=4'b0011 with both enabled, score=254 -> score=255 saturated, kill count +2.
REQ-038 SHALL check: dead=1 with 3 enemies live -> OVER, enemy_en=0, score held; start -> score=0, RUN.
REQ-039 SHALL check: RESET=0 asserted mid-RUN between Clk edges -> outputs reach reset values without a Clk edge.
